// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver state encoding, parity codes and the
// default line settings that the transmitter also uses.
package uart_receiver_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 115_200;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB-first, optional odd/even parity, one stop bit,
// mid-bit sampling, one-cycle rx_valid strobe with parity/framing flags.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic [1:0] parity_type,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

  rx_state_t   state, next_state;
  parity_t     par_mode;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        par_err;
  logic        stop_bit;
  logic        frame_done;
  logic        half_hit;
  logic        bit_hit;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (rx_s)
  );

  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == BIT_LAST);
  assign rx_busy  = (state != RX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      RX_IDLE:      if (!rx_s) next_state = RX_START;
      RX_START:     if (half_hit) next_state = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (bit_hit && bit_idx == 3'd7)
                      next_state = (par_mode == PAR_NONE) ? RX_STOP : RX_PARITY;
      RX_PARITY:    if (bit_hit) next_state = RX_STOP;
      RX_STOP:      if (bit_hit) next_state = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) next_state = RX_IDLE;
      default:      next_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_mode   <= PAR_NONE;
      par_err    <= 1'b0;
      stop_bit   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          par_mode <= (parity_type == 2'd3) ? PAR_NONE : parity_t'(parity_type);
        end
        RX_START: cnt <= half_hit ? '0 : cnt + 16'd1;
        RX_DATA: begin
          if (bit_hit) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_PARITY: begin
          if (bit_hit) begin
            cnt     <= '0;
            par_err <= ((^shift) ^ rx_s) != (par_mode == PAR_ODD);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (bit_hit) begin
            cnt        <= '0;
            stop_bit   <= rx_s;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_WAIT_HIGH: cnt <= '0;
        default:      cnt <= '0;
      endcase
    end
  end

  // Results are published one cycle after the stop sample; par_mode still holds
  // the frozen per-frame value at that edge even though IDLE re-latches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_valid <= frame_done;
      if (frame_done) begin
        rx_data       <= shift;
        parity_error  <= (par_mode != PAR_NONE) && par_err;
        framing_error <= ~stop_bit;
      end
    end
  end

endmodule
